// File: rtl/yarc_ddr3_wb_arbiter_if.sv
// Pipelined Wishbone bundle shared by the upstream masters and the downstream DDR3 controller port.
// MASTER drives the request; SLAVE drives stall and the response.
interface wishbone_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] sel;
  logic                stall;
  logic                ack;
  logic [DATA_W-1:0]   rdata;
  logic                err;
  logic                rty;

  modport MASTER (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, rdata, err, rty
  );

  modport SLAVE (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, rdata, err, rty
  );
endinterface

// File: rtl/yarc_ddr3_wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter sharing one DDR3 controller port among NUM_PORTS masters.
// An in-order tag FIFO steers each controller ack back to the port that issued the request.
module yarc_ddr3_wb_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MAX_BURST       = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic       i_controller_clk,
  input  logic       i_rst,
  wishbone_if.SLAVE  wb_if [NUM_PORTS],
  wishbone_if.MASTER mem_if
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int FW = $clog2(MAX_OUTSTANDING);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] cyc_v;
  logic [NUM_PORTS-1:0] we_v;
  logic [ADDR_W-1:0]    addr_a  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_a [NUM_PORTS];
  logic [DATA_W/8-1:0]  sel_a   [NUM_PORTS];

  logic [PW-1:0] last_grant;
  logic [BW-1:0] burst_cnt;
  logic [PW-1:0] grant;
  logic          any_req;
  logic          other_req;

  logic [PW-1:0] tag_mem [MAX_OUTSTANDING];
  logic [FW:0]   wr_ptr;
  logic [FW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic [PW-1:0] head;
  logic          push;
  logic          pop;
  logic          unused_resp;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign req[g]     = wb_if[g].cyc & wb_if[g].stb;
    assign cyc_v[g]   = wb_if[g].cyc;
    assign we_v[g]    = wb_if[g].we;
    assign addr_a[g]  = wb_if[g].addr;
    assign wdata_a[g] = wb_if[g].wdata;
    assign sel_a[g]   = wb_if[g].sel;

    assign wb_if[g].stall = (grant == PW'(g)) ? (mem_if.stall | fifo_full) : 1'b1;
    assign wb_if[g].ack   = pop & (head == PW'(g)) & cyc_v[g];
    assign wb_if[g].rdata = mem_if.rdata;
    assign wb_if[g].err   = 1'b0;
    assign wb_if[g].rty   = 1'b0;
  end

  assign any_req   = |req;
  assign other_req = |(req & ~(NUM_PORTS'(1) << last_grant));

  // A zero burst count means nothing was accepted since reset, so the scan starts at port 0.
  always_comb begin
    logic [PW-1:0] cand_idx;
    logic          found;
    int            cand;
    grant    = last_grant;
    cand_idx = '0;
    found    = 1'b0;
    cand     = 0;
    if (req[last_grant] &&
        (((burst_cnt != '0) && (burst_cnt < MAX_B)) || !other_req)) begin
      grant = last_grant;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand     = (int'(last_grant) + k) % NUM_PORTS;
        cand_idx = PW'(cand);
        if (!found && req[cand_idx]) begin
          grant = cand_idx;
          found = 1'b1;
        end
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign head       = tag_mem[rd_ptr[FW-1:0]];

  // cyc stays up while tags are in flight so the controller never aborts pending work.
  assign mem_if.cyc   = any_req | ~fifo_empty;
  assign mem_if.stb   = any_req & ~fifo_full;
  assign mem_if.we    = we_v[grant];
  assign mem_if.addr  = addr_a[grant];
  assign mem_if.wdata = wdata_a[grant];
  assign mem_if.sel   = sel_a[grant];

  assign push = mem_if.stb & ~mem_if.stall;
  assign pop  = mem_if.ack & ~fifo_empty;

  assign unused_resp = mem_if.err | mem_if.rty;

  always_ff @(posedge i_controller_clk) begin
    if (push) begin
      tag_mem[wr_ptr[FW-1:0]] <= grant;
    end
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      last_grant <= PW'(NUM_PORTS - 1);
      burst_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + (FW+1)'(1);
        last_grant <= grant;
        if (grant == last_grant) begin
          if (burst_cnt < MAX_B) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end else begin
          burst_cnt <= BW'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (FW+1)'(1);
      end
    end
  end

  // An ack with nothing in flight means the controller and this arbiter disagree.
  assert property (@(posedge i_controller_clk) disable iff (i_rst) !(mem_if.ack && fifo_empty));

endmodule

// File: tb/tb_yarc_ddr3_wb_arbiter.sv
// Randomized bench for yarc_ddr3_wb_arbiter: a transaction-level model (grant rules, tag queue)
// predicts every downstream request, stall and routed ack cycle by cycle.
module tb_yarc_ddr3_wb_arbiter;

  localparam int NP = 3;
  localparam int MO = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_if wb [NP] ();
  wishbone_if mem ();

  yarc_ddr3_wb_arbiter #(
    .NUM_PORTS(NP),
    .MAX_OUTSTANDING(MO),
    .MAX_BURST(MB)
  ) dut (
    .i_controller_clk(clk),
    .i_rst(rst),
    .wb_if(wb),
    .mem_if(mem)
  );

  logic        cyc_d  [NP];
  logic        stb_d  [NP];
  logic [31:0] addr_d [NP];
  logic [NP-1:0] stall_v, ack_v, side_v;
  logic [31:0] rdata_a [NP];

  for (genvar g = 0; g < NP; g++) begin : g_wire
    assign wb[g].cyc   = cyc_d[g];
    assign wb[g].stb   = stb_d[g];
    assign wb[g].we    = 1'b0;
    assign wb[g].addr  = addr_d[g];
    assign wb[g].wdata = addr_d[g] ^ 32'h5555_5555;
    assign wb[g].sel   = 4'hF;
    assign stall_v[g]  = wb[g].stall;
    assign ack_v[g]    = wb[g].ack;
    assign rdata_a[g]  = wb[g].rdata;
    assign side_v[g]   = wb[g].err | wb[g].rty;
  end

  logic        m_stall, m_ack;
  logic [31:0] m_rdata;
  assign mem.stall = m_stall;
  assign mem.ack   = m_ack;
  assign mem.rdata = m_rdata;
  assign mem.err   = 1'b0;
  assign mem.rty   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int last_m, cnt_m, seq;
  int tagq [$];
  logic [31:0] pend [$];
  int p_start, p_req, p_drop, p_ack, p_stall;

  function automatic logic [31:0] rsp(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    last_m = NP - 1;
    cnt_m  = 0;
    tagq.delete();
    pend.delete();
  endtask

  // Masters hold a stalled request; the memory acks in order with random gaps.
  task automatic applyStimulus(input bit accept, input int g);
    for (int p = 0; p < NP; p++) begin
      if (cyc_d[p] && ($urandom % 100) < p_drop) begin
        cyc_d[p] = 1'b0;
        stb_d[p] = 1'b0;
      end else if (stb_d[p] && !(accept && g == p)) begin
        stb_d[p] = 1'b1;
      end else begin
        if (!cyc_d[p]) cyc_d[p] = (($urandom % 100) < p_start);
        stb_d[p] = cyc_d[p] && (($urandom % 100) < p_req);
        if (stb_d[p]) begin
          addr_d[p] = {8'(p), 8'h00, 16'(seq)};
          seq++;
        end
      end
    end
    m_stall = (($urandom % 100) < p_stall);
    m_ack   = (pend.size() > 0) && (($urandom % 100) < p_ack);
    m_rdata = m_ack ? rsp(pend[0]) : 32'h0;
  endtask

  task automatic runCycle();
    bit req [NP];
    bit any, others, found, full, exp_stb, exp_cyc, accept, pop;
    int g, c;
    logic [NP-1:0] exp_ack, exp_stall;
    @(negedge clk);
    any = 0;
    others = 0;
    for (int p = 0; p < NP; p++) begin
      req[p] = cyc_d[p] && stb_d[p];
      if (req[p]) any = 1;
      if (req[p] && p != last_m) others = 1;
    end
    full = (tagq.size() == MO);
    g = last_m;
    if (!(req[last_m] && ((cnt_m > 0 && cnt_m < MB) || !others))) begin
      found = 0;
      for (int k = 1; k <= NP; k++) begin
        c = (last_m + k) % NP;
        if (!found && req[c]) begin
          g = c;
          found = 1;
        end
      end
    end
    exp_stb = any && !full;
    exp_cyc = any || (tagq.size() > 0);
    accept  = exp_stb && !m_stall;
    pop     = m_ack && (tagq.size() > 0);
    exp_ack = '0;
    if (pop && cyc_d[tagq[0]]) exp_ack[tagq[0]] = 1'b1;
    exp_stall = '1;
    exp_stall[g] = m_stall || full;

    checkOutput("mem_stb", 32'(mem.stb), 32'(exp_stb));
    checkOutput("mem_cyc", 32'(mem.cyc), 32'(exp_cyc));
    checkOutput("ack_vec", 32'(ack_v), 32'(exp_ack));
    checkOutput("err_rty", 32'(side_v), 32'h0);
    if (exp_stb) begin
      checkOutput("mem_addr", mem.addr, addr_d[g]);
      checkOutput("mem_wdata", mem.wdata, addr_d[g] ^ 32'h5555_5555);
    end
    if (any) checkOutput("stall_vec", 32'(stall_v), 32'(exp_stall));
    if (exp_ack != '0) checkOutput("ack_rdata", rdata_a[tagq[0]], rsp(pend[0]));

    @(posedge clk);
    if (rst) begin
      resetModel();
    end else begin
      if (pop) begin
        void'(tagq.pop_front());
        void'(pend.pop_front());
      end
      if (accept) begin
        tagq.push_back(g);
        pend.push_back(addr_d[g]);
        cnt_m  = (g == last_m) ? ((cnt_m < MB) ? cnt_m + 1 : MB) : 1;
        last_m = g;
      end
    end
    #1;
    applyStimulus(accept, g);
  endtask

  task automatic setKnobs(input int s, input int r, input int d, input int a, input int st);
    p_start = s;
    p_req   = r;
    p_drop  = d;
    p_ack   = a;
    p_stall = st;
  endtask

  initial begin
    rst = 1'b1;
    seq = 0;
    for (int p = 0; p < NP; p++) begin
      cyc_d[p]  = 1'b0;
      stb_d[p]  = 1'b0;
      addr_d[p] = 32'h0;
    end
    m_stall = 1'b0;
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    setKnobs(0, 0, 0, 0, 0);
    resetModel();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    runCycle();
    setKnobs(100, 100, 0, 60, 0);
    repeat (150) runCycle();
    setKnobs(100, 70, 0, 0, 10);
    repeat (40) runCycle();
    setKnobs(100, 70, 0, 40, 10);
    repeat (60) runCycle();
    setKnobs(30, 60, 20, 40, 20);
    repeat (1500) runCycle();

    setKnobs(100, 100, 0, 0, 0);
    repeat (10) runCycle();
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    setKnobs(100, 100, 0, 50, 0);
    repeat (100) runCycle();

    setKnobs(0, 0, 100, 100, 0);
    repeat (30) runCycle();
    checkOutput("drained_cyc", 32'(mem.cyc), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
